// File: rtl/piezo_pkg.sv
// piezo_pkg: note codes, FSM/tracker state types, nominal note periods and the charge sequence.
// Latency: none (types and constants only).
// Backpressure: none.
package piezo_pkg;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    G6   = 3'd1,
    C7   = 3'd2,
    E7   = 3'd3,
    G7   = 3'd4,
    UNK  = 3'd7
  } note_t;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEAS      = 1'b1
  } fsm_t;

  // Number of charge-sequence notes matched so far.
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6} seq_t;

  // Nominal waveform periods in clk cycles at 50 MHz.
  localparam int PRD_G6 = 31887;
  localparam int PRD_C7 = 23889;
  localparam int PRD_E7 = 18961;
  localparam int PRD_G7 = 15944;

  localparam note_t CHARGE_SEQ [6] = '{G6, C7, E7, G7, E7, G7};

  // Note the tracker expects next when it is in state s.
  function automatic note_t exp_note(input seq_t s);
    logic [2:0] idx;
    idx = s;
    return (s == S6) ? NONE : CHARGE_SEQ[idx];
  endfunction

endpackage

// File: rtl/piezo_tone_decoder_if.sv
// piezo_tone_decoder_if: tone waveform pair in, note events and status out.
// Latency: none (wires only).
// Backpressure: none; events are one-cycle pulses the listener must sample.
// Ports: piezo/piezo_n (tone pair), note_vld/note_code/note_prds (note event),
//        fanfare (charge sequence pulse), err (sticky error).
interface piezo_tone_decoder_if;
  import piezo_pkg::*;

  logic        piezo;
  logic        piezo_n;
  logic        note_vld;
  note_t       note_code;
  logic [11:0] note_prds;
  logic        fanfare;
  logic        err;

  // master drives the tone pair, slave is the decoder.
  modport master (output piezo, piezo_n, input note_vld, note_code, note_prds, fanfare, err);
  modport slave  (input piezo, piezo_n, output note_vld, note_code, note_prds, fanfare, err);

endinterface

// File: rtl/piezo_prd_meas.sv
// piezo_prd_meas: piezo rise detect, saturating period counter and note classifier.
// Latency: rise/prd/cls are registered one cycle after the clk edge that first sees piezo high.
// Backpressure: none; free-running observer.
// Ports: clk, rst; piezo in; rise (pulse), prd (period P), cls (class of P), cnt (running counter).
module piezo_prd_meas
  import piezo_pkg::*;
#(
  parameter int TOL    = 128,
  parameter int NOM_G6 = PRD_G6,
  parameter int NOM_C7 = PRD_C7,
  parameter int NOM_E7 = PRD_E7,
  parameter int NOM_G7 = PRD_G7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        piezo,
  output logic        rise,
  output logic [15:0] prd,
  output note_t       cls,
  output logic [15:0] cnt
);

  logic        prev_q;
  logic        rise_q;
  logic        rise_c;
  logic [15:0] cnt_q;
  logic [15:0] prd_q;
  note_t       cls_q;

  // |p - nom| <= TOL evaluated in 17-bit signed so the difference cannot wrap.
  function automatic logic near(input logic [15:0] p, input int nom);
    logic signed [16:0] d;
    d = $signed({1'b0, p}) - $signed(17'(nom));
    return (d <= $signed(17'(TOL))) && (d >= -$signed(17'(TOL)));
  endfunction

  function automatic note_t classify(input logic [15:0] p);
    if (near(p, NOM_G6)) return G6;
    if (near(p, NOM_C7)) return C7;
    if (near(p, NOM_E7)) return E7;
    if (near(p, NOM_G7)) return G7;
    return UNK;
  endfunction

  assign rise_c = piezo & ~prev_q;

  // The counter restarts at 1 on a rise, so its value at the next rise is
  // exactly the number of cycles between the two rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
      prd_q  <= '0;
      cls_q  <= NONE;
    end else begin
      prev_q <= piezo;
      rise_q <= rise_c;
      if (rise_c) begin
        cnt_q <= 16'd1;
        prd_q <= cnt_q;
        cls_q <= classify(cnt_q);
      end else if (cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign rise = rise_q;
  assign prd  = prd_q;
  assign cls  = cls_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/piezo_tone_decoder.sv
// piezo_tone_decoder: groups measured piezo periods into note events and spots the charge fanfare.
// Latency: note_vld two cycles after the clk edge that sees the deciding piezo rise, or one cycle after timeout.
// Backpressure: none; note_vld/fanfare are single-cycle pulses, note_code/note_prds held to the next event.
// Ports: clk, rst (sync, active high); bus (slave modport of piezo_tone_decoder_if).
// Build option PIEZO_CHK_EN: also flag illegal piezo/piezo_n combinations on err.
module piezo_tone_decoder
  import piezo_pkg::*;
#(
  parameter int TOL     = 128,
  parameter int SIL_CYC = 40000,
  parameter int NOM_G6  = PRD_G6,
  parameter int NOM_C7  = PRD_C7,
  parameter int NOM_E7  = PRD_E7,
  parameter int NOM_G7  = PRD_G7
) (
  input  logic                 clk,
  input  logic                 rst,
  piezo_tone_decoder_if.slave  bus
);

  logic        rise;
  note_t       cls;
  logic [15:0] cnt;
  logic [15:0] prd_unused;
  logic        tmo;
  logic        chk_err;

  fsm_t        state_q, state_n;
  note_t       cur_q, cur_n;
  logic [11:0] ncnt_q, ncnt_n;
  seq_t        seq_q, seq_n;
  logic        emit;
  logic        fanfare_n;
  logic        err_n;

  logic        note_vld_q;
  note_t       note_code_q;
  logic [11:0] note_prds_q;
  logic        fanfare_q;
  logic        err_q;

  piezo_prd_meas #(
    .TOL    (TOL),
    .NOM_G6 (NOM_G6),
    .NOM_C7 (NOM_C7),
    .NOM_E7 (NOM_E7),
    .NOM_G7 (NOM_G7)
  ) u_meas (
    .clk   (clk),
    .rst   (rst),
    .piezo (bus.piezo),
    .rise  (rise),
    .prd   (prd_unused),
    .cls   (cls),
    .cnt   (cnt)
  );

  // Silence: counter has run SIL_CYC cycles since the last rise.
  assign tmo = (cnt == 16'(SIL_CYC));

`ifdef PIEZO_CHK_EN
  // zz_q counts consecutive both-low cycles in MEAS; the third one is an error.
  logic [1:0] zz_q, zz_n;
  logic       both_hi, both_lo;

  assign both_hi = bus.piezo & bus.piezo_n;
  assign both_lo = ~bus.piezo & ~bus.piezo_n;

  always_comb begin
    zz_n    = 2'd0;
    chk_err = both_hi;
    if (state_q == MEAS && both_lo) begin
      zz_n = (zz_q == 2'd2) ? zz_q : zz_q + 2'd1;
      if (zz_q == 2'd2) chk_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) zz_q <= 2'd0;
    else     zz_q <= zz_n;
  end
`else
  logic unused_piezo_n;
  assign unused_piezo_n = bus.piezo_n;
  assign chk_err        = 1'b0;
`endif

  always_comb begin
    state_n   = state_q;
    cur_n     = cur_q;
    ncnt_n    = ncnt_q;
    seq_n     = seq_q;
    emit      = 1'b0;
    fanfare_n = 1'b0;
    err_n     = err_q | chk_err;

    case (state_q)
      WAIT_EDGE: begin
        // First rise only opens the measurement; its period is meaningless.
        if (rise) begin
          state_n = MEAS;
          cur_n   = NONE;
          ncnt_n  = 12'd0;
        end
      end
      MEAS: begin
        // A rise takes priority over a coincident timeout.
        if (rise) begin
          if (cur_q == NONE) begin
            cur_n  = cls;
            ncnt_n = 12'd1;
          end else if (cls == cur_q) begin
            ncnt_n = (ncnt_q == 12'hFFF) ? ncnt_q : ncnt_q + 12'd1;
          end else begin
            emit   = 1'b1;
            cur_n  = cls;
            ncnt_n = 12'd1;
          end
        end else if (tmo) begin
          emit    = (cur_q != NONE);
          state_n = WAIT_EDGE;
        end
      end
      default: state_n = WAIT_EDGE;
    endcase

    // The emitted event is always (cur_q, ncnt_q).
    if (emit) begin
      if (cur_q == UNK) err_n = 1'b1;
      if (cur_q == exp_note(seq_q)) begin
        if (seq_q == S5) begin
          seq_n     = S0;
          fanfare_n = 1'b1;
        end else begin
          seq_n = seq_t'(seq_q + 3'd1);
        end
      end else begin
        // G6 is the only note that can restart the sequence.
        seq_n = (cur_q == G6) ? S1 : S0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_EDGE;
      cur_q       <= NONE;
      ncnt_q      <= '0;
      seq_q       <= S0;
      note_vld_q  <= 1'b0;
      note_code_q <= NONE;
      note_prds_q <= '0;
      fanfare_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cur_q      <= cur_n;
      ncnt_q     <= ncnt_n;
      seq_q      <= seq_n;
      note_vld_q <= emit;
      fanfare_q  <= fanfare_n;
      err_q      <= err_n;
      if (emit) begin
        note_code_q <= cur_q;
        note_prds_q <= ncnt_q;
      end
    end
  end

  assign bus.note_vld  = note_vld_q;
  assign bus.note_code = note_code_q;
  assign bus.note_prds = note_prds_q;
  assign bus.fanfare   = fanfare_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// tb_piezo_tone_decoder: table vectors, hand sequences and random phrases for piezo_tone_decoder.
// Note periods are scaled down (decoder periods are parameters) to keep the run short.
module tb_piezo_tone_decoder;

  localparam int TOL  = 4;
  localparam int SIL  = 600;
  localparam int P_G6 = 400;
  localparam int P_C7 = 300;
  localparam int P_E7 = 240;
  localparam int P_G7 = 200;

  localparam int C_NONE = 0;
  localparam int C_G6   = 1;
  localparam int C_C7   = 2;
  localparam int C_E7   = 3;
  localparam int C_G7   = 4;
  localparam int C_UNK  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piezo_tone_decoder_if bus ();

  piezo_tone_decoder #(
    .TOL     (TOL),
    .SIL_CYC (SIL),
    .NOM_G6  (P_G6),
    .NOM_C7  (P_C7),
    .NOM_E7  (P_E7),
    .NOM_G7  (P_G7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int code;
    int prds;
    int ff;
  } ev_t;

  typedef struct {
    int prd;
    int reps;
    int code;
    int err;
  } vec_t;

  ev_t  got_q[$];
  ev_t  exp_q[$];
  int   per_q[$];
  int   hist[$];
  int   charge[6] = '{C_G6, C_C7, C_E7, C_G7, C_E7, C_G7};
  int   checks    = 0;
  int   errors    = 0;
  int   ff_pulses = 0;
  int   model_err = 0;
  vec_t tbl[10];

  // Event monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (bus.fanfare === 1'b1) ff_pulses++;
    if (bus.note_vld === 1'b1) begin
      e.code = int'(bus.note_code);
      e.prds = int'(bus.note_prds);
      e.ff   = int'(bus.fanfare);
      got_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_p(input logic v);
    bus.piezo   = v;
    bus.piezo_n = ~v;
  endtask

  // One waveform period: the rise at its start closes the previous period.
  task automatic play(input int p);
    set_p(1'b1);
    hold(p / 2);
    set_p(1'b0);
    hold(p - p / 2);
  endtask

  // Final rise closes the last period, then silence long enough for the timeout event.
  task automatic close_phrase();
    set_p(1'b1);
    hold(2);
    set_p(1'b0);
    hold(SIL + 20);
  endtask

  task automatic do_reset();
    set_p(1'b0);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(2);
    got_q.delete();
    exp_q.delete();
    hist.delete();
    model_err = 0;
  endtask

  function automatic int nom_of(input int code);
    case (code)
      C_G6:    return P_G6;
      C_C7:    return P_C7;
      C_E7:    return P_E7;
      default: return P_G7;
    endcase
  endfunction

  // Reference model: classify by distance, run-length group, suffix-match the charge sequence.
  function automatic int classify(input int p);
    int nom[4] = '{P_G6, P_C7, P_E7, P_G7};
    for (int i = 0; i < 4; i++)
      if (p - nom[i] <= TOL && nom[i] - p <= TOL) return i + 1;
    return C_UNK;
  endfunction

  task automatic push_ev(input int code, input int n);
    ev_t e;
    int  ff;
    ff = 0;
    hist.push_back(code);
    if (code == C_UNK) model_err = 1;
    if (hist.size() >= 6) begin
      ff = 1;
      for (int k = 0; k < 6; k++)
        if (hist[hist.size() - 6 + k] != charge[k]) ff = 0;
    end
    if (ff != 0) hist.delete();
    e.code = code;
    e.prds = (n > 4095) ? 4095 : n;
    e.ff   = ff;
    exp_q.push_back(e);
  endtask

  task automatic model_phrase();
    int c;
    int n;
    int k;
    c = -1;
    n = 0;
    foreach (per_q[i]) begin
      k = classify(per_q[i]);
      if (k == c) begin
        n++;
      end else begin
        if (c >= 0) push_ev(c, n);
        c = k;
        n = 1;
      end
    end
    if (c >= 0) push_ev(c, n);
    per_q.delete();
  endtask

  task automatic add_exp(input int code, input int prds, input int ff);
    ev_t e;
    e.code = code;
    e.prds = prds;
    e.ff   = ff;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    chk($sformatf("%s count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s ev%0d code", tag, i), got_q[i].code, exp_q[i].code);
      chk($sformatf("%s ev%0d prds", tag, i), got_q[i].prds, exp_q[i].prds);
      chk($sformatf("%s ev%0d fanfare", tag, i), got_q[i].ff, exp_q[i].ff);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f0;
    int nn;
    int sel;
    int reps;
    int p;

    // {period, repetitions, expected code, expected sticky err}
    tbl[0] = '{P_G6,           20, C_G6,  0};
    tbl[1] = '{P_C7,            3, C_C7,  0};
    tbl[2] = '{P_E7,            2, C_E7,  0};
    tbl[3] = '{P_G7,            2, C_G7,  0};
    tbl[4] = '{P_G6 + TOL,      2, C_G6,  0};
    tbl[5] = '{P_G6 - TOL,      2, C_G6,  0};
    tbl[6] = '{P_G7 - TOL,      1, C_G7,  0};
    tbl[7] = '{P_G7 + TOL,      1, C_G7,  0};
    tbl[8] = '{P_G7 + TOL + 1,  3, C_UNK, 1};
    tbl[9] = '{P_C7 - TOL - 1,  2, C_UNK, 1};

    // Reset state
    set_p(1'b0);
    rst = 1'b1;
    hold(3);
    chk("reset note_vld",  bus.note_vld,  0);
    chk("reset note_code", bus.note_code, C_NONE);
    chk("reset note_prds", bus.note_prds, 0);
    chk("reset fanfare",   bus.fanfare,   0);
    chk("reset err",       bus.err,       0);
    rst = 1'b0;
    hold(2);

    // Single-note phrases from the table
    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].reps) play(tbl[i].prd);
      close_phrase();
      add_exp(tbl[i].code, tbl[i].reps, 0);
      compare_events($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d err", i), bus.err, tbl[i].err);
      chk($sformatf("tbl%0d code held", i), bus.note_code, tbl[i].code);
    end

    // C7 x10 straight into E7 x5: change of note, then timeout
    do_reset();
    repeat (10) play(P_C7);
    repeat (5) play(P_E7);
    close_phrase();
    add_exp(C_C7, 10, 0);
    add_exp(C_E7, 5, 0);
    compare_events("c7_e7");

    // Full charge sequence at nominal periods
    f0 = ff_pulses;
    for (int k = 0; k < 6; k++) repeat (2) play(nom_of(charge[k]));
    close_phrase();
    for (int k = 0; k < 6; k++) add_exp(charge[k], 2, (k == 5) ? 1 : 0);
    compare_events("charge");
    chk("charge fanfare pulses", ff_pulses - f0, 1);

    // False start G6,C7 then the full sequence
    f0 = ff_pulses;
    play(P_G6); play(P_C7); play(P_G6); play(P_C7);
    play(P_E7); play(P_G7); play(P_E7); play(P_G7);
    close_phrase();
    add_exp(C_G6, 1, 0); add_exp(C_C7, 1, 0); add_exp(C_G6, 1, 0); add_exp(C_C7, 1, 0);
    add_exp(C_E7, 1, 0); add_exp(C_G7, 1, 0); add_exp(C_E7, 1, 0); add_exp(C_G7, 1, 1);
    compare_events("restart");
    chk("restart fanfare pulses", ff_pulses - f0, 1);

    // Just outside the G7 window gives UNK and err
    do_reset();
    repeat (3) play(P_G7 + TOL + 1);
    close_phrase();
    add_exp(C_UNK, 3, 0);
    compare_events("unk");
    chk("unk err", bus.err, 1);

    // UNK inside a partial sequence sends the tracker back to the start
    f0 = ff_pulses;
    play(P_G6); play(P_C7); play(P_E7); play(P_G7 + TOL + 3);
    play(P_G7); play(P_E7); play(P_G7);
    close_phrase();
    add_exp(C_G6, 1, 0); add_exp(C_C7, 1, 0); add_exp(C_E7, 1, 0); add_exp(C_UNK, 1, 0);
    add_exp(C_G7, 1, 0); add_exp(C_E7, 1, 0); add_exp(C_G7, 1, 0);
    compare_events("unk_seq");
    chk("unk_seq fanfare pulses", ff_pulses - f0, 0);

    // Reset in the middle of a C7 note: no event, outputs cleared next cycle
    repeat (8) play(P_C7);
    rst = 1'b1;
    hold(1);
    chk("midrst note_vld",  bus.note_vld,  0);
    chk("midrst note_code", bus.note_code, C_NONE);
    chk("midrst note_prds", bus.note_prds, 0);
    chk("midrst fanfare",   bus.fanfare,   0);
    chk("midrst err",       bus.err,       0);
    hold(2);
    rst = 1'b0;
    hold(SIL + 20);
    chk("midrst no event", got_q.size(), 0);
    got_q.delete();

    // Random phrases against the reference model
    do_reset();
    for (int r = 0; r < 4; r++) begin
      nn = $urandom_range(1, 5);
      for (int j = 0; j < nn; j++) begin
        sel  = $urandom_range(0, 5);
        reps = $urandom_range(1, 3);
        if (sel < 4) begin
          repeat (reps) begin
            p = nom_of(sel + 1) + int'($urandom_range(0, 2 * TOL)) - TOL;
            per_q.push_back(p);
          end
        end else if (sel == 4) begin
          repeat (reps) per_q.push_back(P_G7 + TOL + 1 + int'($urandom_range(0, 20)));
        end else begin
          for (int k = 0; k < 6; k++) per_q.push_back(nom_of(charge[k]));
        end
      end
      foreach (per_q[i]) play(per_q[i]);
      close_phrase();
      model_phrase();
      compare_events($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d err", r), bus.err, model_err);
    end

`ifdef PIEZO_CHK_EN
    // Both lines high for a single cycle is an error that sticks
    do_reset();
    chk("pair err before", bus.err, 0);
    bus.piezo   = 1'b1;
    bus.piezo_n = 1'b1;
    hold(1);
    set_p(1'b0);
    hold(1);
    chk("pair both-high err", bus.err, 1);
    hold(5);
    chk("pair err sticky", bus.err, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
